uart_tx_frame: RTL
==================

Name: uart_tx_frame

Overview:
- UART transmit framer, directly downstream of the baud-tick generator (clk_gen).
- Accepts bytes over a valid/ready handshake and drives the generator's uart_en while a frame is in flight.
- Consumes the generator's one-cycle bps_clk tick to time each bit, and serialises start, data (LSB first) and stop bits onto txd.

Parameters:
- DATA_BITS, 8: data bits per frame; legal range 5..8.
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2.
- PARITY_ODD, 0: parity sense; 0 = even, 1 = odd. Used only with UART_TX_PARITY_EN.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- bps_clk  input  1  one-clk-wide bit tick from the baud generator.
- uart_en  output  1  enable request to the baud generator.
- tx_data  input  DATA_BITS  byte to send; sampled on handshake.
- tx_valid  input  1  upstream has data.
- tx_ready  output  1  block can accept tx_data this cycle.
- txd  output  1  serial line; idle high.
- tx_busy  output  1  a frame is in progress.
- tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- All outputs are registered.
- Reset values: txd=1, tx_ready=1, uart_en=0, tx_busy=0, tx_done=0. State is IDLE.
- FSM states are IDLE, WAIT, START, DATA, PAR, STOP.
- IDLE:
  - txd=1, tx_ready=1, uart_en=0.
  - On tx_valid && tx_ready: latch tx_data into the shift register; next cycle go to WAIT with tx_ready=0, tx_busy=1, uart_en=1.
- WAIT:
  - txd stays 1.
  - On the first bps_clk: txd<=0 and go to START. The start bit is exactly one tick period.
- START: on bps_clk, txd<=shift[0], bit counter<=0, go to DATA.
- DATA:
  - On each bps_clk: shift right and increment the counter.
  - When counter==DATA_BITS-1: go to PAR if parity is compiled in, otherwise txd<=1 and go to STOP.
- PAR: exists only under UART_TX_PARITY_EN (see Optional Feature).
- STOP:
  - txd=1; the stop counter counts bps_clk ticks.
  - On the STOP_BITS-th tick: go to IDLE, with uart_en<=0, tx_busy<=0, tx_ready<=1 and tx_done=1 for one cycle.
- Every bit lasts exactly one tick-to-tick interval. Latency from handshake to the txd falling edge is 1 cycle plus the delay to the first bps_clk.
- bps_clk is ignored in IDLE.
- tx_valid is ignored while tx_ready=0. tx_data changes after acceptance have no effect.
- Back-to-back frames: IDLE lasts at least one cycle, so uart_en drops for at least one cycle. This restarts the generator phase for each frame.
- Asynchronous rst mid-frame: txd returns to 1 immediately, the FSM goes to IDLE, and the frame is dropped with no tx_done.
- A bps_clk coinciding with the handshake cycle is ignored.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - After the last data bit, state PAR drives the parity bit for one tick period, then STOP follows.
  - Parity is the XOR of the latched data bits, inverted when PARITY_ODD=1.
  - Parity is computed at latch time.
- Undefined: no PAR state and no parity logic; DATA goes straight to STOP.

Test Plan:
- Basic frame: bench pulses bps_clk every 16 clk; send 0xA5 with 8N1 -> txd is 0,1,0,1,0,0,1,0,1,1, each bit 16 clk. tx_done pulses once. uart_en is high from handshake+1 until the final tick.
- Back-to-back: tx_valid held with 0x00 then 0xFF -> two full frames. tx_ready high for exactly one cycle between them. uart_en low for at least 1 cycle between frames.
- STOP_BITS=2 with DATA_BITS=7: send 0x55 -> frame is 10 bit periods with two stop periods, and the 8th data-width bit is not sent.
- Parity (UART_TX_PARITY_EN):
  - 0xA5 with PARITY_ODD=0 -> parity bit 0.
  - 0x01 with PARITY_ODD=0 -> parity bit 1.
  - 0x01 with PARITY_ODD=1 -> parity bit 0.
- Reset mid-frame: assert rst during data bit 3 -> txd=1 immediately, then tx_ready=1, uart_en=0, no tx_done. The next frame sent afterwards is correct.
- Spurious ticks and busy writes: bps_clk pulses in IDLE -> txd stays 1. tx_valid during a frame with 0x3C -> ignored, and the frame in flight is unchanged.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional parity and stop bits, one bit per bps_clk tick.
// Optional parity bit after the data bits is compiled in by defining UART_TX_PARITY_EN.

module uart_tx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bps_clk,
    output logic                 uart_en,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CW = $clog2(DATA_BITS);

    // Reject parameter values the framing logic is not built for.
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
`ifdef UART_TX_PARITY_EN
        ST_PAR   = 3'd4,
`endif
        ST_STOP  = 3'd5
    } state_e;

    state_e                 state_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   shift_d;
    logic [CW-1:0]          bit_cnt_q;
    logic                   stop_cnt_q;
    logic                   txd_q;
    logic                   tx_ready_q;
    logic                   uart_en_q;
    logic                   tx_busy_q;
    logic                   tx_done_q;

`ifdef UART_TX_PARITY_EN
    logic                   parity_q;
    logic                   parity_d;

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data);
        return (^data) ^ (PARITY_ODD != 0);
    endfunction
`endif

    // Next shift-register contents and, when compiled in, the parity of the byte being offered.
    always_comb begin
        shift_d = shift_q >> 1;
`ifdef UART_TX_PARITY_EN
        parity_d = calc_parity(tx_data);
`endif
    end

    // Frame sequencer with all outputs registered; bps_clk is only honoured once a frame is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            txd_q      <= 1'b1;
            tx_ready_q <= 1'b1;
            uart_en_q  <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            tx_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    txd_q      <= 1'b1;
                    tx_ready_q <= 1'b1;
                    uart_en_q  <= 1'b0;
                    tx_busy_q  <= 1'b0;
                    if (tx_valid && tx_ready_q) begin
                        shift_q    <= tx_data;
`ifdef UART_TX_PARITY_EN
                        parity_q   <= parity_d;
`endif
                        tx_ready_q <= 1'b0;
                        tx_busy_q  <= 1'b1;
                        uart_en_q  <= 1'b1;
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // The generator restarts with uart_en, so its first tick opens the start bit.
                    if (bps_clk) begin
                        txd_q   <= 1'b0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (bps_clk) begin
                        txd_q     <= shift_q[0];
                        bit_cnt_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bps_clk) begin
                        if (bit_cnt_q == CW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            txd_q   <= parity_q;
                            state_q <= ST_PAR;
`else
                            txd_q      <= 1'b1;
                            stop_cnt_q <= 1'b0;
                            state_q    <= ST_STOP;
`endif
                        end else begin
                            txd_q     <= shift_d[0];
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + CW'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PAR: begin
                    if (bps_clk) begin
                        txd_q      <= 1'b1;
                        stop_cnt_q <= 1'b0;
                        state_q    <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    txd_q <= 1'b1;
                    if (bps_clk) begin
                        if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                            uart_en_q  <= 1'b0;
                            tx_busy_q  <= 1'b0;
                            tx_ready_q <= 1'b1;
                            tx_done_q  <= 1'b1;
                            state_q    <= ST_IDLE;
                        end else begin
                            stop_cnt_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    txd_q      <= 1'b1;
                    tx_ready_q <= 1'b1;
                    uart_en_q  <= 1'b0;
                    tx_busy_q  <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign txd      = txd_q;
    assign tx_ready = tx_ready_q;
    assign uart_en  = uart_en_q;
    assign tx_busy  = tx_busy_q;
    assign tx_done  = tx_done_q;

endmodule
